control_sequencer: RTL and testbench

CONTROL_SEQUENCER -- requirements
Module: control_sequencer

---
 rtl/control_sequencer.sv | 152 +++++++++++++++
 tb/tb_control_sequencer.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/control_sequencer.sv
`timescale 1ns/1ps
// Hardwired control unit: fetch (T0-T2) then a three- or four-step execute (T3-T6),
// with absorbing HALTED/FAULT states. Moore outputs from state and latched IR fields.
module control_sequencer #(
   parameter int             NREGS   = 16,
   parameter int             OPW     = 5,
   parameter logic [OPW-1:0] MUL_OP  = 5'b01110,
   parameter logic [OPW-1:0] DIV_OP  = 5'b01111,
   parameter logic [OPW-1:0] HALT_OP = 5'b11011
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             run,
   input  logic [31:0]      ir,
   input  logic             mem_ready,
   output logic             pc_out,
   output logic             mar_in,
   output logic             inc_pc,
   output logic             pc_in,
   output logic             read,
   output logic             mdr_in,
   output logic             mdr_out,
   output logic             ir_in,
   output logic             y_in,
   output logic             zlo_in,
   output logic             zhi_in,
   output logic             zlo_out,
   output logic             zhi_out,
   output logic             hi_in,
   output logic             lo_in,
   output logic [OPW-1:0]   alu_op,
   output logic [NREGS-1:0] r_in,
   output logic [NREGS-1:0] r_out,
   output logic             busy,
   output logic             halted,
   output logic             fault
);

   typedef enum logic [3:0] {
      S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_HALTED, S_FAULT
   } state_e;

   state_e         state_q, state_d;
   logic           first_q;
   logic [OPW-1:0] op_q;
   logic [3:0]     ra_q, rb_q, rc_q;
   logic           muldiv;
   logic           ir_halt, ir_bad;
   logic           unused_ir;

   assign unused_ir = ^ir[14:0];
   assign muldiv    = (op_q == MUL_OP) || (op_q == DIV_OP);
   assign ir_halt   = (OPW'(ir[31:27]) == HALT_OP);
   assign ir_bad    = ({1'b0, ir[26:23]} >= 5'(NREGS)) ||
                      ({1'b0, ir[22:19]} >= 5'(NREGS)) ||
                      ({1'b0, ir[18:15]} >= 5'(NREGS));

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         state_q <= S_IDLE;
         first_q <= 1'b0;
         op_q    <= '0;
         ra_q    <= '0;
         rb_q    <= '0;
         rc_q    <= '0;
      end else begin
         state_q <= state_d;
         // pc_in is a single-cycle strobe even when T1 stretches for memory
         first_q <= (state_q == S_T0);
         if (state_q == S_T2) begin
            op_q <= OPW'(ir[31:27]);
            ra_q <= ir[26:23];
            rb_q <= ir[22:19];
            rc_q <= ir[18:15];
         end
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE:   if (run) state_d = S_T0;
         S_T0:     state_d = S_T1;
         S_T1:     if (mem_ready) state_d = S_T2;
         // halt wins over a bad register index
         S_T2:     state_d = ir_halt ? S_HALTED : (ir_bad ? S_FAULT : S_T3);
         S_T3:     state_d = S_T4;
         S_T4:     state_d = S_T5;
         S_T5:     state_d = muldiv ? S_T6 : (run ? S_T0 : S_IDLE);
         S_T6:     state_d = run ? S_T0 : S_IDLE;
         S_HALTED: state_d = S_HALTED;
         S_FAULT:  state_d = S_FAULT;
         default:  state_d = S_IDLE;
      endcase
   end

   always_comb begin
      pc_out  = 1'b0;
      mar_in  = 1'b0;
      inc_pc  = 1'b0;
      pc_in   = 1'b0;
      read    = 1'b0;
      mdr_in  = 1'b0;
      mdr_out = 1'b0;
      ir_in   = 1'b0;
      y_in    = 1'b0;
      zlo_in  = 1'b0;
      zhi_in  = 1'b0;
      zlo_out = 1'b0;
      zhi_out = 1'b0;
      hi_in   = 1'b0;
      lo_in   = 1'b0;
      alu_op  = '0;
      r_in    = '0;
      r_out   = '0;
      busy    = 1'b0;
      halted  = 1'b0;
      fault   = 1'b0;
      unique case (state_q)
         S_T0: begin
            pc_out = 1'b1; mar_in = 1'b1; inc_pc = 1'b1; zlo_in = 1'b1; busy = 1'b1;
         end
         S_T1: begin
            zlo_out = 1'b1; pc_in = first_q; read = 1'b1; mdr_in = 1'b1; busy = 1'b1;
         end
         S_T2: begin
            mdr_out = 1'b1; ir_in = 1'b1; busy = 1'b1;
         end
         S_T3: begin
            y_in = 1'b1; busy = 1'b1;
         end
         S_T4: begin
            zlo_in = 1'b1; zhi_in = muldiv; alu_op = op_q; busy = 1'b1;
         end
         S_T5: begin
            zlo_out = 1'b1; lo_in = muldiv; busy = 1'b1;
         end
         S_T6: begin
            zhi_out = 1'b1; hi_in = 1'b1; busy = 1'b1;
         end
         S_HALTED: halted = 1'b1;
         S_FAULT:  fault  = 1'b1;
         default:  ;
      endcase
      for (int i = 0; i < NREGS; i++) begin
         r_out[i] = ((state_q == S_T3) && (rb_q == 4'(i))) ||
                    ((state_q == S_T4) && (rc_q == 4'(i)));
         r_in[i]  = (state_q == S_T5) && !muldiv && (ra_q == 4'(i));
      end
   end

endmodule

// File: tb/tb_control_sequencer.sv
`timescale 1ns/1ps
// Scoreboard bench: stimulus queues the expected per-cycle output vector,
// a negedge monitor pops and compares. Second instance uses NREGS=8.
module tb_control_sequencer;

   typedef struct packed {
      logic [14:0] s;
      logic [4:0]  alu;
      logic [15:0] rin;
      logic [15:0] rout;
      logic        busy;
      logic        halted;
      logic        fault;
   } outv_t;

   typedef struct {
      string nm;
      outv_t v;
   } exp_t;

   localparam logic [14:0] PC_OUT  = 15'h0001, MAR_IN  = 15'h0002, INC_PC = 15'h0004,
                           PC_IN   = 15'h0008, READ    = 15'h0010, MDR_IN = 15'h0020,
                           MDR_OUT = 15'h0040, IR_IN   = 15'h0080, Y_IN   = 15'h0100,
                           ZLO_IN  = 15'h0200, ZHI_IN  = 15'h0400, ZLO_OUT = 15'h0800,
                           ZHI_OUT = 15'h1000, HI_IN   = 15'h2000, LO_IN  = 15'h4000;

   logic        clk, clr, clr8, run, run8, mem_ready;
   logic [31:0] ir, ir8;
   logic [14:0] s1, s8;
   logic [4:0]  alu1, alu8;
   logic [15:0] rin1, rout1;
   logic [7:0]  rin8, rout8;
   logic        b1, h1, f1, b8, h8, f8;
   outv_t       a1, a8;
   exp_t        q1[$], q8[$];
   exp_t        m1, m8;
   int          n_chk = 0, n_fail = 0;
   outv_t       T0X, T1F, T1W, T2X, IDL, HLT, FLT;
   logic [31:0] AND_IR, MUL_IR;

   control_sequencer dut (
      .clk(clk), .clr(clr), .run(run), .ir(ir), .mem_ready(mem_ready),
      .pc_out(s1[0]), .mar_in(s1[1]), .inc_pc(s1[2]), .pc_in(s1[3]), .read(s1[4]),
      .mdr_in(s1[5]), .mdr_out(s1[6]), .ir_in(s1[7]), .y_in(s1[8]), .zlo_in(s1[9]),
      .zhi_in(s1[10]), .zlo_out(s1[11]), .zhi_out(s1[12]), .hi_in(s1[13]), .lo_in(s1[14]),
      .alu_op(alu1), .r_in(rin1), .r_out(rout1), .busy(b1), .halted(h1), .fault(f1)
   );

   control_sequencer #(.NREGS(8)) dut8 (
      .clk(clk), .clr(clr8), .run(run8), .ir(ir8), .mem_ready(mem_ready),
      .pc_out(s8[0]), .mar_in(s8[1]), .inc_pc(s8[2]), .pc_in(s8[3]), .read(s8[4]),
      .mdr_in(s8[5]), .mdr_out(s8[6]), .ir_in(s8[7]), .y_in(s8[8]), .zlo_in(s8[9]),
      .zhi_in(s8[10]), .zlo_out(s8[11]), .zhi_out(s8[12]), .hi_in(s8[13]), .lo_in(s8[14]),
      .alu_op(alu8), .r_in(rin8), .r_out(rout8), .busy(b8), .halted(h8), .fault(f8)
   );

   assign a1 = {s1, alu1, rin1, rout1, b1, h1, f1};
   assign a8 = {s8, alu8, 8'h00, rin8, 8'h00, rout8, b8, h8, f8};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic outv_t ev(logic [14:0] s, logic [4:0] alu, logic [15:0] rin,
                                logic [15:0] rout, logic b, logic h, logic f);
      return {s, alu, rin, rout, b, h, f};
   endfunction

   task automatic chk(input string nm, input outv_t a, input outv_t e);
      n_chk++;
      if (a !== e) begin
         n_fail++;
         $display("FAIL %s: got s=%h alu=%h rin=%h rout=%h bhf=%b%b%b, expected s=%h alu=%h rin=%h rout=%h bhf=%b%b%b",
                  nm, a.s, a.alu, a.rin, a.rout, a.busy, a.halted, a.fault,
                  e.s, e.alu, e.rin, e.rout, e.busy, e.halted, e.fault);
      end
   endtask

   always @(negedge clk) begin
      if (q1.size() != 0) begin
         m1 = q1.pop_front();
         chk(m1.nm, a1, m1.v);
      end
      if (q8.size() != 0) begin
         m8 = q8.pop_front();
         chk(m8.nm, a8, m8.v);
      end
   end

   task automatic put(input bit d8, input string nm, input outv_t v);
      exp_t e;
      e.nm = nm;
      e.v  = v;
      if (d8) q8.push_back(e);
      else    q1.push_back(e);
   endtask

   // expected outputs for the state entered at the next rising edge
   task automatic tick(input bit d8, input string nm, input outv_t v);
      @(posedge clk);
      #1;
      put(d8, nm, v);
   endtask

   // clr pulsed low between edges: outputs must clear with no clock edge
   task automatic areset(input bit d8, input string nm);
      @(posedge clk);
      #2;
      if (d8) clr8 = 1'b0;
      else    clr  = 1'b0;
      put(d8, nm, '0);
      #5;
      if (d8) clr8 = 1'b1;
      else    clr  = 1'b1;
   endtask

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish, expected completion");
      $fatal(1);
   end

   initial begin
      clr = 1'b0; clr8 = 1'b0; run = 1'b0; run8 = 1'b0; mem_ready = 1'b1;
      ir = '0; ir8 = '0;
      T0X = ev(PC_OUT | MAR_IN | INC_PC | ZLO_IN, 5'd0, 16'h0, 16'h0, 1'b1, 1'b0, 1'b0);
      T1F = ev(ZLO_OUT | PC_IN | READ | MDR_IN, 5'd0, 16'h0, 16'h0, 1'b1, 1'b0, 1'b0);
      T1W = ev(ZLO_OUT | READ | MDR_IN, 5'd0, 16'h0, 16'h0, 1'b1, 1'b0, 1'b0);
      T2X = ev(MDR_OUT | IR_IN, 5'd0, 16'h0, 16'h0, 1'b1, 1'b0, 1'b0);
      IDL = '0;
      HLT = ev(15'h0, 5'd0, 16'h0, 16'h0, 1'b0, 1'b1, 1'b0);
      FLT = ev(15'h0, 5'd0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1);
      AND_IR = 32'h28918000;
      MUL_IR = {5'b01110, 4'd1, 4'd2, 4'd3, 15'd0};

      put(0, "reset", IDL);
      put(1, "reset8", IDL);
      repeat (2) @(posedge clk);
      #1 clr = 1'b1;
      tick(0, "idle", IDL);

      // and R1,R2,R3 followed back-to-back by mul
      ir = AND_IR; run = 1'b1;
      tick(0, "and_t0", T0X);
      tick(0, "and_t1", T1F);
      tick(0, "and_t2", T2X);
      tick(0, "and_t3", ev(Y_IN, 5'd0, 16'h0, 16'h0004, 1'b1, 1'b0, 1'b0));
      tick(0, "and_t4", ev(ZLO_IN, 5'b00101, 16'h0, 16'h0008, 1'b1, 1'b0, 1'b0));
      tick(0, "and_t5", ev(ZLO_OUT, 5'd0, 16'h0002, 16'h0, 1'b1, 1'b0, 1'b0));
      ir = MUL_IR;
      tick(0, "mul_t0", T0X);
      tick(0, "mul_t1", T1F);
      tick(0, "mul_t2", T2X);
      tick(0, "mul_t3", ev(Y_IN, 5'd0, 16'h0, 16'h0004, 1'b1, 1'b0, 1'b0));
      tick(0, "mul_t4", ev(ZLO_IN | ZHI_IN, 5'b01110, 16'h0, 16'h0008, 1'b1, 1'b0, 1'b0));
      tick(0, "mul_t5", ev(ZLO_OUT | LO_IN, 5'd0, 16'h0, 16'h0, 1'b1, 1'b0, 1'b0));
      run = 1'b0;
      tick(0, "mul_t6", ev(ZHI_OUT | HI_IN, 5'd0, 16'h0, 16'h0, 1'b1, 1'b0, 1'b0));
      tick(0, "mul_idle", IDL);

      // three memory wait cycles, then run dropped in T4
      ir = AND_IR; run = 1'b1; mem_ready = 1'b0;
      tick(0, "wait_t0", T0X);
      tick(0, "wait_t1a", T1F);
      tick(0, "wait_t1b", T1W);
      tick(0, "wait_t1c", T1W);
      tick(0, "wait_t1d", T1W);
      mem_ready = 1'b1;
      tick(0, "wait_t2", T2X);
      tick(0, "wait_t3", ev(Y_IN, 5'd0, 16'h0, 16'h0004, 1'b1, 1'b0, 1'b0));
      tick(0, "wait_t4", ev(ZLO_IN, 5'b00101, 16'h0, 16'h0008, 1'b1, 1'b0, 1'b0));
      run = 1'b0;
      tick(0, "drop_t5", ev(ZLO_OUT, 5'd0, 16'h0002, 16'h0, 1'b1, 1'b0, 1'b0));
      tick(0, "drop_idle", IDL);

      // halt is absorbing until an asynchronous clear
      ir = {5'b11011, 27'd0}; run = 1'b1;
      tick(0, "halt_t0", T0X);
      tick(0, "halt_t1", T1F);
      tick(0, "halt_t2", T2X);
      tick(0, "halted", HLT);
      run = 1'b0;
      tick(0, "halted_run0", HLT);
      run = 1'b1;
      tick(0, "halted_run1", HLT);
      run = 1'b0;
      areset(0, "clr_halted");
      tick(0, "post_clr", IDL);

      // clear during a T1 wait, then first T0 right after release
      ir = AND_IR; mem_ready = 1'b0; run = 1'b1;
      tick(0, "t1clr_t0", T0X);
      tick(0, "t1clr_t1", T1F);
      tick(0, "t1clr_wait", T1W);
      run = 1'b0;
      areset(0, "clr_t1wait");
      tick(0, "t1clr_idle", IDL);
      mem_ready = 1'b1; run = 1'b1;
      tick(0, "first_t0", T0X);
      run = 1'b0;
      tick(0, "norun_t1", T1F);
      tick(0, "norun_t2", T2X);
      tick(0, "norun_t3", ev(Y_IN, 5'd0, 16'h0, 16'h0004, 1'b1, 1'b0, 1'b0));
      tick(0, "norun_t4", ev(ZLO_IN, 5'b00101, 16'h0, 16'h0008, 1'b1, 1'b0, 1'b0));
      tick(0, "norun_t5", ev(ZLO_OUT, 5'd0, 16'h0002, 16'h0, 1'b1, 1'b0, 1'b0));
      tick(0, "norun_idle", IDL);

      // NREGS=8: Ra=9 faults; halt opcode outranks the bad index
      ir8 = {5'b00101, 4'd9, 4'd2, 4'd3, 15'd0}; run8 = 1'b1;
      @(posedge clk);
      #1 clr8 = 1'b1;
      tick(1, "f8_t0", T0X);
      tick(1, "f8_t1", T1F);
      tick(1, "f8_t2", T2X);
      tick(1, "fault", FLT);
      run8 = 1'b0;
      tick(1, "fault_run0", FLT);
      run8 = 1'b1;
      tick(1, "fault_run1", FLT);
      run8 = 1'b0;
      areset(1, "clr_fault");
      ir8 = {5'b11011, 4'd9, 4'd2, 4'd3, 15'd0}; run8 = 1'b1;
      tick(1, "hp_t0", T0X);
      tick(1, "hp_t1", T1F);
      tick(1, "hp_t2", T2X);
      tick(1, "halt_prio", HLT);

      @(negedge clk);
      #1;
      if (q1.size() != 0 || q8.size() != 0) begin
         n_chk++;
         n_fail++;
         $display("FAIL drain: %0d/%0d expectations left unchecked, expected 0", q1.size(), q8.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
